mux_nto1_rr: RTL

Parametrised N-to-1 registered stream multiplexer. It is the successor to the combinational 2:1 mux. It merges N_CH valid/ready input channels onto one registered output stream. Channel selection is either an externally driven select or an internal round-robin arbiter. It sits in front of shared datapath consumers that need one arbitrated input stream with a fixed one-cycle latency.

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_nto1_rr_arbiter.sv | 63 ++++++
 rtl/mux_nto1_rr.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants for the registered N-to-1 stream multiplexer.
//   MODE_FIXED : channel chosen by the external sel input
//   MODE_RR    : channel chosen by the internal round-robin arbiter
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_nto1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Rotating-priority arbiter. ptr_reg remembers the last granted channel; the
// search for the next grant starts at ptr_reg+1 and wraps modulo N_CH.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (ptr -> N_CH-1, so ch0 wins first)
//   req      in   [N_CH]  request vector
//   advance  in   1 when the current grant was consumed; ptr takes gnt_idx
//   gnt_idx  out  [SEL_W] index of the winning request
//   gnt_any  out  1 when any request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W-1:0] ptr_reg;

  // cand[k] is the channel at priority position k: (ptr + 1 + k) mod N_CH.
  // Computed with one extra bit so the wrap works for non-power-of-two N_CH.
  logic [SEL_W-1:0] cand [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_cand
      logic [SEL_W:0] sum;
      assign sum = {1'b0, ptr_reg} + (SEL_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (SEL_W+1)'(N_CH)) ?
                        SEL_W'(sum - (SEL_W+1)'(N_CH)) : sum[SEL_W-1:0];
    end
  endgenerate

  // Walk from lowest priority to highest so the highest-priority hit is the
  // last assignment and therefore wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        gnt_idx = cand[k];
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= SEL_W'(N_CH - 1);
    end else if (advance) begin
      ptr_reg <= gnt_idx;
    end
  end

endmodule : rr_arbiter

// File: rtl/mux_nto1_rr.sv
// -----------------------------------------------------------------------------
// mux_nto1_rr
// Registered N-to-1 valid/ready stream multiplexer with fixed-select or
// round-robin channel selection and a one-cycle output register.
//
// Optional feature macro: MUX_LOCK_EN
//   When defined, adds in_last/out_last and packet lock: a beat without
//   in_last locks the grant onto its channel until a beat with in_last.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mode       in   MODE_FIXED (use sel) / MODE_RR (round-robin)
//   sel        in   [SEL_W] channel index in fixed mode
//   in_valid   in   [N_CH] per-channel valid
//   in_ready   out  [N_CH] per-channel ready (at most one high)
//   in_data    in   [N_CH*WIDTH] channel i at [i*WIDTH +: WIDTH]
//   out_valid  out  output register holds a beat
//   out_ready  in   downstream accepts
//   out_data   out  [WIDTH] registered data
//   out_ch     out  [SEL_W] source channel of out_data
//   in_last    in   [N_CH] end-of-packet marker   (MUX_LOCK_EN only)
//   out_last   out  registered end-of-packet      (MUX_LOCK_EN only)
// -----------------------------------------------------------------------------
module mux_nto1_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch
`ifdef MUX_LOCK_EN
  ,
  input  logic [N_CH-1:0]         in_last,
  output logic                    out_last
`endif
);

  import mux_pkg::*;

  logic                 load;
  logic [SEL_W-1:0]     grant;
  logic                 grant_ok;
  logic                 fixed_ok;
  logic [N_CH-1:0]      fixed_onehot;
  logic [N_CH-1:0]      arb_req;
  logic [SEL_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [N_CH-1:0]      xfer_vec;
  logic                 xfer;
  logic [WIDTH-1:0]     xfer_data;
  logic                 lock_active;
  logic [SEL_W-1:0]     lock_ch;

  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_data_reg;
  logic [SEL_W-1:0]     out_ch_reg;

  assign load     = !out_valid_reg || out_ready;
  assign fixed_ok = ({1'b0, sel} < (SEL_W+1)'(N_CH));

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_chan
      // Channel addressed by the lock or by sel, independent of the arbiter.
      assign fixed_onehot[gi] = lock_active ? (lock_ch == SEL_W'(gi))
                                            : (sel == SEL_W'(gi));
      assign in_ready[gi]     = load && grant_ok && (grant == SEL_W'(gi));
    end
  endgenerate

  // In round-robin (unlocked) the arbiter searches all valids. Otherwise it
  // only sees the channel that can actually transfer, so on a transfer its
  // gnt_idx equals the transferred channel and ptr always records the last
  // transferred channel regardless of mode.
  assign arb_req = (mode == MODE_RR && !lock_active) ? in_valid
                                                     : (in_valid & fixed_onehot);

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (xfer),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    grant    = sel;
    grant_ok = fixed_ok;
    if (lock_active) begin
      grant    = lock_ch;
      grant_ok = 1'b1;
    end else if (mode == MODE_RR) begin
      grant    = arb_idx;
      grant_ok = arb_any;
    end
  end

  assign xfer_vec = in_valid & in_ready;
  assign xfer     = |xfer_vec;

  // xfer_vec is one-hot or zero, so an AND-OR select is sufficient.
  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      xfer_data = xfer_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{xfer_vec[i]}});
    end
  end

  // A new input beat replaces the held beat in the same cycle it drains,
  // so there is no bubble at full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= xfer_data;
      out_ch_reg    <= grant;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

`ifdef MUX_LOCK_EN
  logic             lock_reg;
  logic [SEL_W-1:0] locked_ch_reg;
  logic             out_last_reg;
  logic             xfer_last;

  assign xfer_last = |(xfer_vec & in_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg      <= 1'b0;
      locked_ch_reg <= '0;
      out_last_reg  <= 1'b0;
    end else if (xfer) begin
      lock_reg      <= !xfer_last;
      locked_ch_reg <= grant;
      out_last_reg  <= xfer_last;
    end
  end

  assign lock_active = lock_reg;
  assign lock_ch     = locked_ch_reg;
  assign out_last    = out_last_reg;
`else
  assign lock_active = 1'b0;
  assign lock_ch     = '0;
`endif

endmodule : mux_nto1_rr
